// File: rtl/autosa_acc_shift_feed_pkg.sv
// autosa_acc_shift_feed_pkg: shared widths, clamp limits, feeder state and result record
package autosa_acc_shift_feed_pkg;

    localparam int AUTOSA_ACC_WIDTH   = 49;
    localparam int AUTOSA_SHIFT_WIDTH = 6;
    localparam int AUTOSA_PROD_WIDTH  = 34;
    localparam int AUTOSA_CNT_WIDTH   = 16;

    localparam logic signed [AUTOSA_ACC_WIDTH-1:0] AUTOSA_ACC_MAX = {1'b0, {(AUTOSA_ACC_WIDTH-1){1'b1}}};
    localparam logic signed [AUTOSA_ACC_WIDTH-1:0] AUTOSA_ACC_MIN = {1'b1, {(AUTOSA_ACC_WIDTH-1){1'b0}}};

    typedef enum logic {
        S_IDLE,
        S_ACC
    } feed_state_e;

    typedef struct packed {
        logic signed [AUTOSA_ACC_WIDTH-1:0]   data;
        logic signed [AUTOSA_SHIFT_WIDTH-1:0] shift;
        logic                                 sat;
        logic [AUTOSA_CNT_WIDTH-1:0]          cnt;
    } autosa_result_t;

endpackage

// File: rtl/autosa_acc_shift_feed_if.sv
// autosa_acc_shift_feed_if: product beat input and accumulated result output channels
interface autosa_acc_shift_feed_if
    import autosa_acc_shift_feed_pkg::*;
#(
    parameter int PROD_WIDTH  = AUTOSA_PROD_WIDTH,
    parameter int ACC_WIDTH   = AUTOSA_ACC_WIDTH,
    parameter int SHIFT_WIDTH = AUTOSA_SHIFT_WIDTH,
    parameter int CNT_WIDTH   = AUTOSA_CNT_WIDTH
);
    logic                          in_pvld;
    logic                          in_prdy;
    logic signed [PROD_WIDTH-1:0]  in_prod;
    logic                          in_last;
    logic signed [SHIFT_WIDTH-1:0] in_shift;
    logic                          out_pvld;
    logic                          out_prdy;
    logic signed [ACC_WIDTH-1:0]   out_data;
    logic signed [SHIFT_WIDTH-1:0] out_shift;
    logic                          out_sat;
    logic [CNT_WIDTH-1:0]          out_cnt;

    modport master (
        output in_pvld, in_prod, in_last, in_shift, out_prdy,
        input  in_prdy, out_pvld, out_data, out_shift, out_sat, out_cnt
    );

    modport slave (
        input  in_pvld, in_prod, in_last, in_shift, out_prdy,
        output in_prdy, out_pvld, out_data, out_shift, out_sat, out_cnt
    );
endinterface

// File: rtl/autosa_sat_add.sv
// autosa_sat_add: one-bit-wider signed add of a product into the accumulator, clamped to the accumulator range
module autosa_sat_add
    import autosa_acc_shift_feed_pkg::*;
#(
    parameter int ACC_WIDTH  = AUTOSA_ACC_WIDTH,
    parameter int PROD_WIDTH = AUTOSA_PROD_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]  base,
    input  logic signed [PROD_WIDTH-1:0] prod,
    output logic signed [ACC_WIDTH-1:0]  sum,
    output logic                         sat
);
    logic [ACC_WIDTH:0] wide;

    // The extra bit holds the exact sum, so a top-two-bit disagreement is precisely an out-of-range result
    assign wide = {base[ACC_WIDTH-1], base} + {{(ACC_WIDTH+1-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign sat  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    assign sum  = ~sat ? wide[ACC_WIDTH-1:0] :
                  wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
endmodule

// File: rtl/autosa_acc_shift_feed.sv
// autosa_acc_shift_feed: accumulates last-terminated product groups and presents each clamped sum with its shift
module autosa_acc_shift_feed
    import autosa_acc_shift_feed_pkg::*;
#(
    parameter int PROD_WIDTH  = AUTOSA_PROD_WIDTH,
    parameter int ACC_WIDTH   = AUTOSA_ACC_WIDTH,
    parameter int SHIFT_WIDTH = AUTOSA_SHIFT_WIDTH,
    parameter int CNT_WIDTH   = AUTOSA_CNT_WIDTH
) (
    input logic autosa_core_clk,
    input logic autosa_core_rst,
    autosa_acc_shift_feed_if.slave bus
);
    feed_state_e                   state, state_next;
    logic                          first, fire, beat_sat, grp_sat, sat_acc;
    logic signed [ACC_WIDTH-1:0]   acc, base, sum;
    logic [CNT_WIDTH-1:0]          cnt_acc, cnt_next;
    logic signed [SHIFT_WIDTH-1:0] shift_acc, shift_cur;

    assign first       = state == S_IDLE;
    assign bus.in_prdy = ~bus.out_pvld | bus.out_prdy;
    assign fire        = bus.in_pvld & bus.in_prdy;
    assign base        = first ? '0 : acc;
    assign grp_sat     = (~first & sat_acc) | beat_sat;
    assign cnt_next    = first ? CNT_WIDTH'(1) : (&cnt_acc ? cnt_acc : cnt_acc + CNT_WIDTH'(1));
    assign shift_cur   = first ? bus.in_shift : shift_acc;

    autosa_sat_add #(
        .ACC_WIDTH  (ACC_WIDTH),
        .PROD_WIDTH (PROD_WIDTH)
    ) u_sat_add (
        .base (base),
        .prod (bus.in_prod),
        .sum  (sum),
        .sat  (beat_sat)
    );

    // An accepted last beat returns to idle so the next beat starts a fresh group
    always_comb begin
        state_next = state;
        if (fire) state_next = bus.in_last ? S_IDLE : S_ACC;
    end

    // Group state register
    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) state <= S_IDLE;
        else state <= state_next;
    end

    // Running sum, sticky clamp, beat count and group shift for a group still in progress
    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            acc       <= '0;
            sat_acc   <= 1'b0;
            cnt_acc   <= '0;
            shift_acc <= '0;
        end else if (fire & ~bus.in_last) begin
            acc       <= sum;
            sat_acc   <= grp_sat;
            cnt_acc   <= cnt_next;
            shift_acc <= shift_cur;
        end
    end

    // Result register: a last beat loads it even while draining, so groups flow back-to-back
    always_ff @(posedge autosa_core_clk) begin
        if (autosa_core_rst) begin
            bus.out_pvld  <= 1'b0;
            bus.out_data  <= '0;
            bus.out_shift <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_cnt   <= '0;
        end else if (fire & bus.in_last) begin
            bus.out_pvld  <= 1'b1;
            bus.out_data  <= sum;
            bus.out_shift <= shift_cur;
            bus.out_sat   <= grp_sat;
            bus.out_cnt   <= cnt_next;
        end else if (bus.out_prdy) begin
            bus.out_pvld  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_autosa_acc_shift_feed.sv
// tb_autosa_acc_shift_feed: directed and random groups checked against a group-level reference model
module tb_autosa_acc_shift_feed;
    import autosa_acc_shift_feed_pkg::*;

    localparam longint AMAX = (longint'(1) <<< 48) - 1;
    localparam longint AMIN = -(longint'(1) <<< 48);
    localparam longint PMAX = (longint'(1) <<< 33) - 1;
    localparam longint PMIN = -(longint'(1) <<< 33);

    typedef struct {
        longint data;
        longint shift;
        bit     sat;
        longint cnt;
    } res_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     n_checks = 0;
    int     n_fail = 0;
    bit     rnd = 1'b0;
    res_t   exp_q[$];
    longint m_acc, m_shift, m_cnt;
    bit     m_first = 1'b1;
    bit     m_sat;
    bit     hold_prev = 1'b0;
    longint prev_data, prev_shift, prev_cnt;
    bit     prev_sat;

    always #5 clk = ~clk;

    autosa_acc_shift_feed_if bus ();
    autosa_acc_shift_feed_if #(.CNT_WIDTH(4)) bus4 ();

    assign bus4.in_pvld  = bus.in_pvld;
    assign bus4.in_prod  = bus.in_prod;
    assign bus4.in_last  = bus.in_last;
    assign bus4.in_shift = bus.in_shift;
    assign bus4.out_prdy = bus.out_prdy;

    autosa_acc_shift_feed dut (
        .autosa_core_clk (clk),
        .autosa_core_rst (rst),
        .bus             (bus)
    );

    autosa_acc_shift_feed #(.CNT_WIDTH(4)) dut4 (
        .autosa_core_clk (clk),
        .autosa_core_rst (rst),
        .bus             (bus4)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sat_cnt(input longint c, input longint lim);
        return c > lim ? lim : c;
    endfunction

    task automatic check_out(input longint d, input longint sh, input longint s, input longint c);
        check("out_pvld", longint'(bus.out_pvld), 1);
        check("out_data", longint'(bus.out_data), d);
        check("out_shift", longint'(bus.out_shift), sh);
        check("out_sat", longint'(bus.out_sat), s);
        check("out_cnt", longint'(bus.out_cnt), sat_cnt(c, 65535));
        check("out_cnt4", longint'(bus4.out_cnt), sat_cnt(c, 15));
    endtask

    task automatic check_idle();
        check("rst_pvld", longint'(bus.out_pvld), 0);
        check("rst_data", longint'(bus.out_data), 0);
        check("rst_shift", longint'(bus.out_shift), 0);
        check("rst_sat", longint'(bus.out_sat), 0);
        check("rst_cnt", longint'(bus.out_cnt), 0);
        check("rst_prdy", longint'(bus.in_prdy), 1);
    endtask

    task automatic send(input longint p, input bit last, input longint sh);
        int w = 0;
        bus.in_pvld  = 1'b1;
        bus.in_prod  = p[33:0];
        bus.in_last  = last;
        bus.in_shift = sh[5:0];
        if (rnd) bus.out_prdy = $urandom_range(0, 2) != 0;
        forever begin
            @(negedge clk);
            if (bus.in_prdy) break;
            if (w == 200) begin
                check("send_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) bus.out_prdy = $urandom_range(0, 2) != 0;
            w++;
        end
        @(posedge clk);
        #1;
        bus.in_pvld = 1'b0;
    endtask

    // Reference model: groups are summed and clamped beat by beat; results queue until drained
    always @(negedge clk) begin : monitor
        longint p, s, c, sh;
        bit bs, gs;
        res_t r;
        if (rst) begin
            exp_q.delete();
            m_first   = 1'b1;
            hold_prev = 1'b0;
        end else begin
            check("pvld", longint'(bus.out_pvld), longint'(exp_q.size() != 0));
            check("pvld4", longint'(bus4.out_pvld), longint'(exp_q.size() != 0));
            check("prdy", longint'(bus.in_prdy), longint'(exp_q.size() == 0 || bus.out_prdy));
            if (hold_prev) begin
                check("hold_data", longint'(bus.out_data), prev_data);
                check("hold_shift", longint'(bus.out_shift), prev_shift);
                check("hold_sat", longint'(bus.out_sat), longint'(prev_sat));
                check("hold_cnt", longint'(bus.out_cnt), prev_cnt);
            end
            if (bus.out_pvld && bus.out_prdy && exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("q_data", longint'(bus.out_data), r.data);
                check("q_shift", longint'(bus.out_shift), r.shift);
                check("q_sat", longint'(bus.out_sat), longint'(r.sat));
                check("q_cnt", longint'(bus.out_cnt), sat_cnt(r.cnt, 65535));
                check("q_cnt4", longint'(bus4.out_cnt), sat_cnt(r.cnt, 15));
            end
            hold_prev  = bus.out_pvld && !bus.out_prdy;
            prev_data  = bus.out_data;
            prev_shift = bus.out_shift;
            prev_sat   = bus.out_sat;
            prev_cnt   = longint'(bus.out_cnt);
            if (bus.in_pvld && bus.in_prdy) begin
                p  = bus.in_prod;
                s  = (m_first ? 0 : m_acc) + p;
                bs = 1'b0;
                if (s > AMAX) begin
                    s  = AMAX;
                    bs = 1'b1;
                end else if (s < AMIN) begin
                    s  = AMIN;
                    bs = 1'b1;
                end
                gs = (!m_first && m_sat) || bs;
                c  = m_first ? 1 : m_cnt + 1;
                sh = m_first ? longint'(bus.in_shift) : m_shift;
                if (bus.in_last) begin
                    r.data  = s;
                    r.shift = sh;
                    r.sat   = gs;
                    r.cnt   = c;
                    exp_q.push_back(r);
                    m_first = 1'b1;
                end else begin
                    m_acc   = s;
                    m_sat   = gs;
                    m_cnt   = c;
                    m_shift = sh;
                    m_first = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint p;
        int len;
        bus.in_pvld  = 1'b0;
        bus.in_prod  = '0;
        bus.in_last  = 1'b0;
        bus.in_shift = '0;
        bus.out_prdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle();
        send(5, 0, 4);
        send(-2, 0, 7);
        send(10, 1, -1);
        check_out(13, 4, 0, 3);
        send(-7, 1, -3);
        check_out(-7, -3, 0, 1);
        repeat (32768) send(PMAX, 0, 0);
        send(PMAX, 1, 0);
        check_out(AMAX, 0, 1, 32769);
        send(1, 1, 5);
        check_out(1, 5, 0, 1);
        @(posedge clk);
        #1;
        bus.out_prdy = 1'b0;
        send(100, 1, 2);
        check_out(100, 2, 0, 1);
        bus.in_pvld  = 1'b1;
        bus.in_prod  = 34'sd55;
        bus.in_last  = 1'b1;
        bus.in_shift = 6'sd1;
        repeat (5) begin
            @(negedge clk);
            check("bp_prdy", longint'(bus.in_prdy), 0);
            check("bp_data", longint'(bus.out_data), 100);
        end
        @(posedge clk);
        #1;
        bus.out_prdy = 1'b1;
        @(posedge clk);
        #1;
        bus.in_pvld = 1'b0;
        check_out(55, 1, 0, 1);
        send(1, 0, 0);
        send(2, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle();
        send(9, 1, 0);
        check_out(9, 0, 0, 1);
        repeat (19) send(1, 0, 0);
        send(1, 1, 0);
        check_out(20, 0, 0, 20);
        repeat (32768) send(PMIN, 0, 0);
        send(-1, 0, 0);
        send(7, 1, 0);
        check_out(AMIN + 7, 0, 1, 32770);
        rnd = 1'b1;
        for (int g = 0; g < 60; g++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                case ($urandom_range(0, 3))
                    0: p = PMAX;
                    1: p = PMIN;
                    default: p = $signed({$urandom, $urandom}) >>> 30;
                endcase
                send(p, b == len - 1, longint'($urandom_range(0, 63)) - 32);
            end
        end
        rnd = 1'b0;
        bus.out_prdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("final_drain", longint'(bus.out_pvld), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
